parking_occupancy: RTL and testbench

Parametrised per-bay vehicle occupancy monitor for the parking system. It takes N raw IR sensor lines and synchronises and debounces each one independently. It keeps a registered occupancy vector plus aggregate occupied/free counts and full/empty flags, and emits one-cycle arrival/departure pulses. It also drives the bay status LEDs and feeds the display/gate controller with counts and flags.

---
 rtl/parking_occupancy.sv | 102 ++++++++++
 tb/tb_parking_occupancy.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_occupancy.sv
// Per-bay IR occupancy monitor: synchronise, debounce, mask, count and flag
// bay occupancy, with one-cycle arrival/departure pulses per bay.
module parking_occupancy #(
  parameter int N_SLOTS         = 6,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int IR_ACTIVE_LOW   = 1,
  parameter int CNT_W           = $clog2(N_SLOTS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SLOTS-1:0] ir,
  input  logic [N_SLOTS-1:0] slot_en,
  output logic [N_SLOTS-1:0] occupied,
  output logic [N_SLOTS-1:0] led,
  output logic [CNT_W-1:0]   occ_count,
  output logic [CNT_W-1:0]   free_count,
  output logic               full,
  output logic               empty,
  output logic [N_SLOTS-1:0] arrive,
  output logic [N_SLOTS-1:0] depart
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SLOTS-1:0] present_raw;
  logic [N_SLOTS-1:0] s1, s2;
  logic [N_SLOTS-1:0] st, st_d;
  logic [DB_W-1:0]    cnt [N_SLOTS];
  logic [N_SLOTS-1:0] occ_next;
  logic [CNT_W-1:0]   en_count;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_SLOTS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign present_raw = (IR_ACTIVE_LOW != 0) ? ~ir : ir;

  // Synchroniser carries decoded presence, so the vacant level is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= present_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        if (s2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          st[i]  <= ~st[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign occ_next = st & slot_en;

  // Events follow st edges, not occupied edges, so masking never pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_d      <= '0;
      occupied  <= '0;
      arrive    <= '0;
      depart    <= '0;
      occ_count <= '0;
    end else begin
      st_d      <= st;
      occupied  <= occ_next;
      arrive    <= st & ~st_d & slot_en;
      depart    <= ~st & st_d & slot_en;
      occ_count <= popcount(occ_next);
    end
  end

  assign en_count = popcount(slot_en);

  // Guard covers the one cycle between a slot_en drop and the count update.
  always_comb begin
    free_count = '0;
    if (en_count > occ_count) free_count = en_count - occ_count;
  end

  assign led   = ~occupied;
  assign full  = (free_count == '0) && (en_count != '0);
  assign empty = (occ_count == '0);

endmodule

// File: tb/tb_parking_occupancy.sv
// Scoreboard bench for parking_occupancy with six bays and a 4-cycle debounce.
module tb_parking_occupancy;

  logic       clk;
  logic       rst;
  logic [5:0] ir;
  logic [5:0] slot_en;
  logic [5:0] occupied, led, arrive, depart;
  logic [2:0] occ_count, free_count;
  logic       full, empty;

  typedef struct packed {
    logic [5:0] occ;
    logic [5:0] led;
    logic [5:0] arr;
    logic [5:0] dep;
    logic [2:0] oc;
    logic [2:0] fc;
    logic       full;
    logic       empty;
  } status_t;

  typedef struct {
    int      dly;
    string   name;
    status_t s;
  } exp_t;

  exp_t    sb[$];
  exp_t    e;
  status_t obs;
  int      total = 0;
  int      bad = 0;

  parking_occupancy #(
    .N_SLOTS(6),
    .DEBOUNCE_CYCLES(4),
    .IR_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ir(ir),
    .slot_en(slot_en),
    .occupied(occupied),
    .led(led),
    .occ_count(occ_count),
    .free_count(free_count),
    .full(full),
    .empty(empty),
    .arrive(arrive),
    .depart(depart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {occupied, led, arrive, depart, occ_count, free_count, full, empty};

  function automatic logic [2:0] pc(input logic [5:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 6; i++) c = c + 3'(v[i]);
    return c;
  endfunction

  function automatic status_t mk(input logic [5:0] occ, input logic [5:0] arr,
                                 input logic [5:0] dep, input logic [5:0] en);
    status_t s;
    s.occ   = occ;
    s.led   = ~occ;
    s.arr   = arr;
    s.dep   = dep;
    s.oc    = pc(occ);
    s.fc    = pc(en) - pc(occ);
    s.full  = (s.fc == 3'd0) && (pc(en) != 3'd0);
    s.empty = (s.oc == 3'd0);
    return s;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input string n, input status_t s);
    exp_t x;
    x.dly  = d;
    x.name = n;
    x.s    = s;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1; ir = 6'h3F; slot_en = 6'h3F;
    push_exp(2, "reset_state", mk(6'h00, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
    rst = 1'b0;
    push_exp(3, "idle_after_reset", mk(6'h00, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
  endtask

  task automatic test_arrive();
    ir[0] = 1'b0;
    push_exp(5, "arrive_wait", mk(6'h00, 6'h00, 6'h00, 6'h3F));
    push_exp(1, "arrive_edge5", mk(6'h00, 6'h00, 6'h00, 6'h3F));
    push_exp(1, "arrive_edge6", mk(6'h01, 6'h01, 6'h00, 6'h3F));
    push_exp(1, "arrive_after", mk(6'h01, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
  endtask

  task automatic test_glitch();
    ir[1] = 1'b0;
    step(3);
    ir[1] = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(1, "glitch_reject", mk(6'h01, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
    ir[1] = 1'b0;
    push_exp(6, "steady_wait", mk(6'h01, 6'h00, 6'h00, 6'h3F));
    push_exp(1, "steady_accept", mk(6'h03, 6'h02, 6'h00, 6'h3F));
    push_exp(1, "steady_after", mk(6'h03, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
  endtask

  task automatic test_all_bays();
    ir = 6'h3F;
    push_exp(6, "release_wait", mk(6'h03, 6'h00, 6'h00, 6'h3F));
    push_exp(1, "release_depart", mk(6'h00, 6'h00, 6'h03, 6'h3F));
    push_exp(1, "release_after", mk(6'h00, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
    ir = 6'h00;
    push_exp(6, "all_wait", mk(6'h00, 6'h00, 6'h00, 6'h3F));
    push_exp(1, "all_arrive", mk(6'h3F, 6'h3F, 6'h00, 6'h3F));
    push_exp(1, "all_full", mk(6'h3F, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
    ir = 6'h04;
    push_exp(6, "bay2_wait", mk(6'h3F, 6'h00, 6'h00, 6'h3F));
    push_exp(1, "bay2_depart", mk(6'h3B, 6'h00, 6'h04, 6'h3F));
    push_exp(1, "bay2_after", mk(6'h3B, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
  endtask

  task automatic test_mask();
    ir = 6'h30;
    push_exp(7, "swap_events", mk(6'h0F, 6'h04, 6'h30, 6'h3F));
    push_exp(1, "swap_after", mk(6'h0F, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
    slot_en = 6'h3C;
    push_exp(1, "mask_apply", mk(6'h0C, 6'h00, 6'h00, 6'h3C));
    push_exp(1, "mask_hold", mk(6'h0C, 6'h00, 6'h00, 6'h3C));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
    slot_en = 6'h3F;
    push_exp(1, "unmask", mk(6'h0F, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
    slot_en = 6'h00;
    push_exp(1, "all_disabled", mk(6'h00, 6'h00, 6'h00, 6'h00));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
    slot_en = 6'h3F;
    push_exp(1, "reenable", mk(6'h0F, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
  endtask

  task automatic test_reset_mid();
    ir[4] = 1'b0;
    step(4);
    rst = 1'b1;
    push_exp(1, "rst_mid", mk(6'h00, 6'h00, 6'h00, 6'h3F));
    push_exp(1, "rst_mid_hold", mk(6'h00, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
    rst = 1'b0;
    push_exp(5, "post_rst_wait", mk(6'h00, 6'h00, 6'h00, 6'h3F));
    push_exp(1, "post_rst_edge5", mk(6'h00, 6'h00, 6'h00, 6'h3F));
    push_exp(1, "post_rst_accept", mk(6'h1F, 6'h1F, 6'h00, 6'h3F));
    push_exp(1, "post_rst_after", mk(6'h1F, 6'h00, 6'h00, 6'h3F));
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e.dly); total++;
      if (obs !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arrive();
    test_glitch();
    test_all_bays();
    test_mask();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
